// File: rtl/rc5_key_schedule.sv
// RC5-16 key expansion: builds S[0..t-1] from a 128-bit user key and streams the
// finished table to the cipher engine's subkey storage, holding it off via busy.
module rc5_key_schedule #(
  parameter int unsigned W          = 16,
  parameter int unsigned KEY_BYTES  = 16,
  parameter int unsigned MAX_ROUNDS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [4:0]             num_rounds_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   sk_we_o,
  output logic [5:0]             sk_addr_o,
  output logic [W-1:0]           sk_data_o
);

  localparam int unsigned C    = KEY_BYTES / 2;
  localparam int unsigned TMax = 2 * (MAX_ROUNDS + 1);
  localparam int unsigned AW   = 6;
  localparam int unsigned NW   = $clog2(3 * TMax + 1);
  localparam int unsigned CW   = $clog2(C);
  localparam int unsigned RotW = $clog2(W);
  localparam logic [W-1:0] MagicP = 16'hB7E1;
  localparam logic [W-1:0] MagicQ = 16'h9E37;

  typedef enum logic [2:0] {StIdle, StInit, StMix, StWrite, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   t_q, t_d;
  logic [NW-1:0]   nmix_q, nmix_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   k_q, k_d;
  logic [CW-1:0]   j_q, j_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    p_q, p_d;
  logic [W-1:0]    s_q [TMax];
  logic [W-1:0]    s_d [TMax];
  logic [W-1:0]    l_q [C];
  logic [W-1:0]    l_d [C];
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [W-1:0]    data_q, data_d;

  logic [4:0]      r_clamp;
  logic [AW-1:0]   t_new;
  logic [NW-1:0]   t_floor;
  logic [NW-1:0]   nmix_new;
  logic [W-1:0]    a_new;
  logic [W-1:0]    ab_sum;
  logic [W-1:0]    b_new;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RotW-1:0] n);
    logic [2*W-1:0] tmp;
    tmp = {x, x} << n;
    return tmp[2*W-1:W];
  endfunction

  assign r_clamp  = (num_rounds_i > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : num_rounds_i;
  assign t_new    = AW'({r_clamp, 1'b0}) + AW'(2);
  assign t_floor  = (t_new > AW'(8)) ? NW'(t_new) : NW'(8);
  assign nmix_new = NW'(3) * t_floor;

  // One mixing iteration; A' feeds B' combinationally in the same cycle.
  assign a_new  = rotl(s_q[k_q] + a_q + b_q, RotW'(3));
  assign ab_sum = a_new + b_q;
  assign b_new  = rotl(l_q[j_q] + ab_sum, ab_sum[RotW-1:0]);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    nmix_d  = nmix_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    s_d     = s_q;
    l_d     = l_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    data_d  = '0;

    unique case (state_q)
      StIdle: begin
        // The done pulse cycle still counts as part of the finished run.
        if (start_i && !done_q) begin
          t_d    = t_new;
          nmix_d = nmix_new;
          k_d    = '0;
          p_d    = MagicP;
          for (int i = 0; i < C; i++) begin
            l_d[i] = key_i[W*i +: W];
          end
          busy_d  = 1'b1;
          state_d = StInit;
        end
      end
      StInit: begin
        s_d[k_q] = p_q;
        p_d      = p_q + MagicQ;
        if (k_q == t_q - AW'(1)) begin
          k_d     = '0;
          j_d     = '0;
          a_d     = '0;
          b_d     = '0;
          cnt_d   = '0;
          state_d = StMix;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      StMix: begin
        s_d[k_q] = a_new;
        l_d[j_q] = b_new;
        a_d      = a_new;
        b_d      = b_new;
        k_d      = (k_q == t_q - AW'(1)) ? '0 : k_q + AW'(1);
        j_d      = (j_q == CW'(C - 1)) ? '0 : j_q + CW'(1);
        cnt_d    = cnt_q + NW'(1);
        if (cnt_q == nmix_q - NW'(1)) begin
          k_d     = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        we_d   = 1'b1;
        addr_d = k_q;
        data_d = s_q[k_q];
        if (k_q == t_q - AW'(1)) begin
          k_d     = '0;
          state_d = StDone;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      nmix_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      s_q     <= '{default: '0};
      l_q     <= '{default: '0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      nmix_q  <= nmix_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      s_q     <= s_d;
      l_q     <= l_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sk_we_o   = we_q;
  assign sk_addr_o = addr_q;
  assign sk_data_o = data_q;

endmodule
